serial_tx: RTL and testbench

SERIAL_TX -- requirements
Module: serial_tx

---
 rtl/serial_pkg.sv | 16 +
 rtl/serial_tx_fifo.sv | 58 +++++
 rtl/serial_tx.sv | 135 +++++++++++++
 tb/tb_serial_tx.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: definitions shared by the serial transmitter and the future
// receiver.
//   serial_state_t  - frame FSM state encoding (IDLE, START, DATA, STOP)
//   MIN_BIT_PERIOD  - smallest bit period in clocks; lower divider values clamp to it
package serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } serial_state_t;

    localparam int MIN_BIT_PERIOD = 2;

endpackage

// File: rtl/serial_tx_fifo.sv
// serial_tx_fifo: synchronous byte FIFO with a registered read port.
//   clk, reset       - clock, synchronous active-high reset (empties the FIFO)
//   push, wr_data    - write request; ignored while full
//   pop              - read request; ignored while empty
//   rd_data          - head byte, valid from the cycle after the pop
//   full, empty      - occupancy flags
module serial_tx_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage and read register carry data only and are not reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
        if (do_pop)  rd_data     <= mem[rd_ptr];
    end

endmodule

// File: rtl/serial_tx.sv
// serial_tx: FIFO-buffered 8N1 serial transmitter, LSB first, idle-high line.
//   clk, reset   - clock, synchronous active-high reset
//   cfg_divider  - clocks per serial bit, latched per frame, clamped to >= 2
//   in_valid     - byte offered; accepted when in_valid && in_ready
//   in_data      - byte to send
//   in_ready     - FIFO not full
//   ser_tx       - registered serial line output
//   busy         - FIFO non-empty or a frame in flight
module serial_tx
    import serial_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] cfg_divider,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             ser_tx,
    output logic             busy
);

    serial_state_t    state;
    serial_state_t    state_next;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] period;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic [7:0]       fifo_data;
    logic             pop;
    logic             full;
    logic             empty;
    logic             bit_end;

    function automatic logic [DIV_W-1:0] clamp_period(input logic [DIV_W-1:0] div);
        if (div < DIV_W'(MIN_BIT_PERIOD)) return DIV_W'(MIN_BIT_PERIOD);
        return div;
    endfunction

    serial_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     (8)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (in_valid),
        .wr_data (in_data),
        .pop     (pop),
        .rd_data (fifo_data),
        .full    (full),
        .empty   (empty)
    );

    assign in_ready = !full;
    assign busy     = (state != ST_IDLE) || !empty;
    assign bit_end  = (cnt == '0);

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) state_next = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end && bit_idx == 3'd7) state_next = ST_STOP;
            end
            ST_STOP: begin
                // Back-to-back frames: pop straight into the next start bit.
                if (bit_end) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        state_next = ST_START;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            ser_tx  <= 1'b1;
            cnt     <= '0;
            period  <= '0;
            bit_idx <= '0;
        end else begin
            state <= state_next;
            if (pop) begin
                // The start bit does not need the byte, so the line drops
                // while the registered FIFO read is still in flight.
                period  <= clamp_period(cfg_divider);
                cnt     <= clamp_period(cfg_divider) - DIV_W'(1);
                ser_tx  <= 1'b0;
                bit_idx <= '0;
            end else if (state != ST_IDLE) begin
                if (!bit_end) begin
                    cnt <= cnt - DIV_W'(1);
                end else begin
                    cnt <= period - DIV_W'(1);
                    case (state)
                        ST_START: ser_tx <= fifo_data[0];
                        ST_DATA: begin
                            if (bit_idx == 3'd7) begin
                                ser_tx <= 1'b1;
                            end else begin
                                ser_tx  <= shreg[0];
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end
                        default: ser_tx <= 1'b1;
                    endcase
                end
            end
        end
    end

    // Bit 0 goes out directly from the FIFO output; the shifter holds the rest.
    always_ff @(posedge clk) begin
        if (bit_end && state == ST_START)     shreg <= {1'b0, fifo_data[7:1]};
        else if (bit_end && state == ST_DATA) shreg <= {1'b0, shreg[7:1]};
    end

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: randomized self-checking bench for serial_tx. Expected line
// waveforms are built from the byte list and bit periods of each burst.
module tb_serial_tx;

    localparam int FIFO_DEPTH = 8;
    localparam int DIV_W      = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [DIV_W-1:0] cfg_divider;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic             ser_tx;
    logic             busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic       line_q [$];
    logic       busy_q [$];
    logic [7:0] exp_bytes [$];
    int         exp_per [$];

    serial_tx #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DIV_W      (DIV_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_divider (cfg_divider),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .ser_tx      (ser_tx),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // One sample per cycle; sample index n is the n-th clock cycle.
    always @(negedge clk) begin
        line_q.push_back(ser_tx);
        busy_q.push_back(busy);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_period(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    // Offer b until accepted; s_idx is the sample index of the accepting cycle.
    task automatic push_byte(input logic [7:0] b, output int s_idx);
        int  guard;
        bit  done;
        guard    = 0;
        done     = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!done) begin
            s_idx = line_q.size();
            done  = in_ready;
            tick();
            guard++;
            if (!done && guard > 5000) begin
                check("push_timeout", 1, 0);
                done = 1;
            end
        end
        exp_bytes.push_back(b);
    endtask

    task automatic wait_samples(input int n);
        int guard;
        guard = 0;
        while (line_q.size() < n && guard < 20000) begin
            tick();
            guard++;
        end
        if (line_q.size() < n) check("wait_timeout", line_q.size(), n);
        tick();
    endtask

    task automatic wait_until_sample(input int n);
        int guard;
        guard = 0;
        while (line_q.size() < n && guard < 20000) begin
            tick();
            guard++;
        end
        if (line_q.size() != n) check("align_timeout", line_q.size(), n);
    endtask

    // Frames are expected back-to-back from sample 'start', idle afterwards.
    task automatic check_frames(input int start, input string tag);
        int idx;
        int total;
        total = 0;
        foreach (exp_per[i]) total += exp_per[i] * 10;
        wait_samples(start + total + 1);
        idx = start;
        foreach (exp_bytes[f]) begin
            int         p;
            int         errs;
            int         fstart;
            logic [9:0] bits;
            logic [7:0] got;
            p      = exp_per[f];
            bits   = {1'b1, exp_bytes[f], 1'b0};
            errs   = 0;
            fstart = idx;
            for (int b = 0; b < 10; b++) begin
                for (int k = 0; k < p; k++) begin
                    if (line_q[idx] !== bits[b]) errs++;
                    idx++;
                end
            end
            for (int b = 1; b < 9; b++) got[b-1] = line_q[fstart + b * p + p / 2];
            $display("%s frame %0d: byte 0x%02h '%c'", tag, f, got, got);
            check($sformatf("%s_f%0d_timing", tag, f), errs, 0);
            check($sformatf("%s_f%0d_byte", tag, f), got, exp_bytes[f]);
        end
        check({tag, "_idle"}, line_q[idx], 1'b1);
        check({tag, "_busy_last"}, busy_q[idx-1], 1'b1);
        check({tag, "_busy_end"}, busy_q[idx], 1'b0);
        exp_bytes.delete();
        exp_per.delete();
    endtask

    initial begin
        int s0;
        int sx;
        int sy;
        int acc;
        int n;
        int d;
        int zeros;
        logic [7:0] bx;

        reset       = 1'b1;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        cfg_divider = 6;
        tick(); tick(); tick();
        check("rst_ser_tx", ser_tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        reset = 1'b0;
        tick();

        // Single 'A' at divider 6; line drops two cycles after the push.
        push_byte(8'h41, s0);
        in_valid = 1'b0;
        exp_per.push_back(6);
        wait_samples(s0 + 2);
        check("a_latency_high", line_q[s0 + 1], 1'b1);
        check_frames(s0 + 2, "a");

        // Divider 0 and 1 both clamp to a 2-cycle bit.
        for (int i = 0; i < 2; i++) begin
            cfg_divider = i;
            push_byte(8'h55, s0);
            in_valid = 1'b0;
            exp_per.push_back(model_period(i));
            check_frames(s0 + 2, $sformatf("clamp%0d", i));
        end

        // Divider change mid-frame only affects the next frame.
        cfg_divider = 6;
        push_byte(8'h00, s0);
        push_byte(8'hFF, sx);
        in_valid = 1'b0;
        exp_per.push_back(6);
        exp_per.push_back(10);
        repeat (20) tick();
        cfg_divider = 10;
        check_frames(s0 + 2, "divchg");
        cfg_divider = 6;

        // Fill the FIFO behind a frame in flight, then resume on its pop.
        bx = 8'($urandom);
        push_byte(bx, sx);
        in_valid = 1'b0;
        tick(); tick(); tick();
        for (int i = 0; i < 8; i++) push_byte(8'($urandom), sy);
        check("full_ready_low", in_ready, 1'b0);
        check("full_busy", busy, 1'b1);
        push_byte(8'($urandom), sy);
        in_valid = 1'b0;
        check("full_resume_idx", sy, sx + 62);
        repeat (10) exp_per.push_back(6);
        check_frames(sx + 2, "full");

        // Push coinciding with pop at occupancy 3.
        cfg_divider = 4;
        push_byte(8'($urandom), sx);
        in_valid = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) push_byte(8'($urandom), sy);
        in_valid = 1'b0;
        wait_until_sample(sx + 41);
        push_byte(8'($urandom), sy);
        check("pp_same_cycle_idx", sy, sx + 41);
        acc = 0;
        while (in_ready && acc < 10) begin
            push_byte(8'($urandom), sy);
            acc++;
        end
        in_valid = 1'b0;
        check("pp_fill_count", acc, 5);
        repeat (10) exp_per.push_back(4);
        check_frames(sx + 2, "pp");

        // Reset during data bit 4 with three bytes queued.
        cfg_divider = 6;
        bx = 8'($urandom);
        push_byte(bx, s0);
        for (int i = 0; i < 3; i++) push_byte(8'($urandom), sy);
        in_valid = 1'b0;
        wait_until_sample(s0 + 34);
        check("rstmid_bit4", ser_tx, 32'(bx[4]));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstmid_ser_tx", ser_tx, 1'b1);
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_in_ready", in_ready, 1'b1);
        repeat (300) tick();
        zeros = 0;
        for (int i = s0 + 35; i < line_q.size(); i++) if (line_q[i] !== 1'b1) zeros++;
        check("rstmid_silent", zeros, 0);
        check("rstmid_busy_after", busy, 1'b0);
        exp_bytes.delete();
        exp_per.delete();

        // Random bursts.
        for (int it = 0; it < 4; it++) begin
            d = $urandom_range(0, 7);
            n = $urandom_range(1, 10);
            cfg_divider = d;
            for (int i = 0; i < n; i++) begin
                push_byte(8'($urandom), sy);
                if (i == 0) s0 = sy;
                exp_per.push_back(model_period(d));
            end
            in_valid = 1'b0;
            check_frames(s0 + 2, $sformatf("rnd%0d", it));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
